// File: rtl/ext_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ext_pipe_pkg
// Description : Shared control definitions. Holds the immediate-extension
//               operation codes and the default width constants for the
//               extension pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package ext_pipe_pkg;

    // Immediate-extension operation codes. Codes 5-7 are undefined.
    typedef enum logic [2:0] {
        EXTOP_ZERO   = 3'd0,
        EXTOP_SIGN   = 3'd1,
        EXTOP_HIGH   = 3'd2,
        EXTOP_BRANCH = 3'd3,
        EXTOP_JUMP   = 3'd4
    } ext_op_e;

    localparam int C_EXT_OP_W   = 3;
    localparam int C_EXT_DATA_W = 32;
    localparam int C_EXT_IMM_W  = 16;
    localparam int C_EXT_JIMM_W = 26;
    localparam int C_EXT_TAG_W  = 5;
    localparam int C_EXT_DEPTH  = 2;

endpackage : ext_pipe_pkg
`default_nettype wire

// File: rtl/ext_core.sv
`default_nettype none
// ============================================================================
// Module      : ext_core
// Description : Combinational immediate-extension decode. Turns a raw
//               immediate (and PC+4 for jumps) into the extended operand and
//               flags undefined operation codes.
// Revision    : 1.0 - initial release
// ============================================================================
module ext_core
    import ext_pipe_pkg::*;
#(
    parameter int DATA_W = C_EXT_DATA_W,
    parameter int IMM_W  = C_EXT_IMM_W,
    parameter int JIMM_W = C_EXT_JIMM_W
) (
    input  logic [C_EXT_OP_W-1:0] ext_op,
    input  logic [JIMM_W-1:0]     imm_i,
    input  logic [DATA_W-1:0]     pc_i,
    output logic [DATA_W-1:0]     result_o,
    output logic                  illegal_o
);

    logic [IMM_W-1:0]  w_imm16;
    logic [DATA_W-1:0] w_zext;
    logic [DATA_W-1:0] w_sext;
    logic [31:0]       w_high32;
    logic [DATA_W-1:0] w_high;
    logic [DATA_W-1:0] w_branch;
    logic [DATA_W-1:0] w_jump;
    logic              w_unused;

    assign w_imm16  = imm_i[IMM_W-1:0];
    assign w_zext   = DATA_W'(w_imm16);
    assign w_sext   = DATA_W'($signed(w_imm16));
    // The 16-bit upper-immediate lands in bits 31:16, then extends from bit 31
    assign w_high32 = {w_imm16, {(32-IMM_W){1'b0}}};
    assign w_high   = DATA_W'($signed(w_high32));
    assign w_branch = w_sext << 2;
    // Jump keeps the PC region bits above the word-aligned target field
    assign w_jump   = {pc_i[DATA_W-1:JIMM_W+2], imm_i, 2'b00};
    // Low PC bits are replaced by the target field and never observed
    assign w_unused = ^pc_i[JIMM_W+1:0];

    // Select the extended operand; undefined codes fall back to zero-extension
    always_comb begin
        result_o  = w_zext;
        illegal_o = 1'b0;
        case (ext_op)
            EXTOP_ZERO:   result_o = w_zext;
            EXTOP_SIGN:   result_o = w_sext;
            EXTOP_HIGH:   result_o = w_high;
            EXTOP_BRANCH: result_o = w_branch;
            EXTOP_JUMP:   result_o = w_jump;
            default: begin
                result_o  = w_zext;
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule : ext_core
`default_nettype wire

// File: rtl/ext_pipe.sv
`default_nettype none
// ============================================================================
// Module      : ext_pipe
// Description : Immediate-extension stage with a 2-entry in-order result
//               FIFO, valid/ready handshakes on both sides, synchronous flush
//               and a sticky undefined-operation flag.
// Revision    : 1.0 - initial release
// ============================================================================
module ext_pipe
    import ext_pipe_pkg::*;
#(
    parameter int DATA_W = C_EXT_DATA_W,
    parameter int IMM_W  = C_EXT_IMM_W,
    parameter int JIMM_W = C_EXT_JIMM_W,
    parameter int TAG_W  = C_EXT_TAG_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [C_EXT_OP_W-1:0] ext_op,
    input  logic [JIMM_W-1:0]     imm_i,
    input  logic [DATA_W-1:0]     pc_i,
    input  logic [TAG_W-1:0]      tag_i,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic [TAG_W-1:0]      out_tag,
    output logic                  op_err
);

    logic [DATA_W-1:0] r_data_q [C_EXT_DEPTH];
    logic [TAG_W-1:0]  r_tag_q  [C_EXT_DEPTH];
    logic              r_head_q;
    logic [1:0]        r_count_q;
    logic              r_op_err_q;

    logic              w_head_d;
    logic [1:0]        w_count_d;
    logic              w_wr_ptr;
    logic              w_push;
    logic              w_pop;
    logic [DATA_W-1:0] w_result;
    logic              w_illegal;

    ext_core #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W),
        .JIMM_W (JIMM_W)
    ) u_core (
        .ext_op    (ext_op),
        .imm_i     (imm_i),
        .pc_i      (pc_i),
        .result_o  (w_result),
        .illegal_o (w_illegal)
    );

    // Handshake status comes purely from registered occupancy
    assign in_ready  = (r_count_q < 2'd2);
    assign out_valid = (r_count_q != 2'd0);
    assign out_data  = r_data_q[r_head_q];
    assign out_tag   = r_tag_q[r_head_q];
    assign op_err    = r_op_err_q;

    assign w_push   = in_valid && in_ready && !flush;
    assign w_pop    = out_valid && out_ready && !flush;
    // Only written when occupancy is 0 or 1, so the tail is head + count[0]
    assign w_wr_ptr = r_head_q ^ r_count_q[0];

    // Next occupancy and head pointer; flush empties the FIFO outright
    always_comb begin
        w_count_d = r_count_q;
        w_head_d  = r_head_q;
        if (flush) begin
            w_count_d = 2'd0;
            w_head_d  = 1'b0;
        end else begin
            case ({w_push, w_pop})
                2'b10: w_count_d = r_count_q + 2'd1;
                2'b01: begin
                    w_count_d = r_count_q - 2'd1;
                    w_head_d  = ~r_head_q;
                end
                2'b11: w_head_d = ~r_head_q;
                default: ;
            endcase
        end
    end

    // FIFO storage, pointers and the sticky undefined-op flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < C_EXT_DEPTH; i++) begin
                r_data_q[i] <= '0;
                r_tag_q[i]  <= '0;
            end
            r_head_q   <= 1'b0;
            r_count_q  <= 2'd0;
            r_op_err_q <= 1'b0;
        end else begin
            r_head_q  <= w_head_d;
            r_count_q <= w_count_d;
            if (w_push) begin
                r_data_q[w_wr_ptr] <= w_result;
                r_tag_q[w_wr_ptr]  <= tag_i;
            end
            if (w_push && w_illegal) begin
                r_op_err_q <= 1'b1;
            end
        end
    end

endmodule : ext_pipe
`default_nettype wire
